// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster-timing bus between the sync generator and the
// game's pixel-colour logic.
//
// Ports / members:
//   ena          run enable into the generator (low freezes all timing state)
//   h, v         current pixel column / line
//   hsync, vsync sync outputs at their configured polarity
//   visible      inside the active picture area
//   col0, row0   h==0 / v==0 debug strobes
//   line_start   one-clock pulse when a new line begins
//   frame_start  one-clock pulse when a new frame begins
//   frame_count  completed-frame counter
//
// Modports: master = the generator, slave = the consumer that drives ena.
interface vga_sync_gen_if #(
  parameter int HW         = 10,
  parameter int VW         = 10,
  parameter int FRAME_BITS = 8
);
  logic                  ena;
  logic [HW-1:0]         h;
  logic [VW-1:0]         v;
  logic                  hsync;
  logic                  vsync;
  logic                  visible;
  logic                  col0;
  logic                  row0;
  logic                  line_start;
  logic                  frame_start;
  logic [FRAME_BITS-1:0] frame_count;

  modport master (
    input  ena,
    output h, v, hsync, vsync, visible, col0, row0,
           line_start, frame_start, frame_count
  );

  modport slave (
    output ena,
    input  h, v, hsync, vsync, visible, col0, row0,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA raster timing generator.
//
// Counts pixels (h) and lines (v) at a pixel rate of clk/CLK_DIV while ena is
// high, and decodes sync, visible-area and start-of-line/frame strobes from
// the counters. Every output is a flop; decoded levels are computed from the
// next-state counters so they line up with the registered h/v.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    vga_sync_gen_if.master (ena in; h, v, hsync, vsync, visible,
//          col0, row0, line_start, frame_start, frame_count out)
//
// The interface instance must be built with HW = clog2(H_TOTAL),
// VW = clog2(V_TOTAL) and the same FRAME_BITS.
module vga_sync_gen #(
  parameter int H_VIEW     = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VIEW     = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int FRAME_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_sync_gen_if.master   bus
);

  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ONE      = HW'(1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_VIEW);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_VIEW + H_FRONT);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_VIEW + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ONE      = VW'(1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_VIEW);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_VIEW + V_FRONT);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_VIEW + V_FRONT + V_SYNC - 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [FRAME_BITS-1:0] FC_ONE = FRAME_BITS'(1);

  // Reject degenerate timings at elaboration so a bad parameter set never
  // silently produces a broken raster.
  if (H_VIEW < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VIEW < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      CLK_DIV < 1 || FRAME_BITS < 1) begin : g_bad_params
    $fatal(1, "vga_sync_gen: every width, CLK_DIV and FRAME_BITS must be >= 1");
  end

  logic [PW-1:0]         pre_q, pre_d;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [FRAME_BITS-1:0] fc_q, fc_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  visible_q, visible_d;
  logic                  col0_q, col0_d;
  logic                  row0_q, row0_d;
  logic                  line_start_q, line_start_d;
  logic                  frame_start_q, frame_start_d;
  logic                  tick;

  // Next-state counters and decode. Levels are decoded from h_d/v_d rather
  // than the current counters so they change on the same edge as h/v; when
  // nothing ticks h_d==h_q and the levels simply hold. vsync only moves when
  // v does, which is only on an h wrap, so it is line-granular for free.
  always_comb begin
    pre_d         = pre_q;
    h_d           = h_q;
    v_d           = v_q;
    fc_d          = fc_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    tick          = bus.ena && (pre_q == PRE_LAST);

    if (bus.ena) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
    end

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d          = '0;
        line_start_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
          fc_d          = fc_q + FC_ONE;
        end else begin
          v_d = v_q + V_ONE;
        end
      end else begin
        h_d = h_q + H_ONE;
      end
    end

    hsync_d   = (h_d >= HS_FIRST && h_d <= HS_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d   = (v_d >= VS_FIRST && v_d <= VS_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
    visible_d = (h_d < H_VIS) && (v_d < V_VIS);
    col0_d    = (h_d == '0);
    row0_d    = (v_d == '0);
  end

  // State and output registers. Reset values match the decode of h=v=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      fc_q          <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      visible_q     <= 1'b1;
      col0_q        <= 1'b1;
      row0_q        <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      h_q           <= h_d;
      v_q           <= v_d;
      fc_q          <= fc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      col0_q        <= col0_d;
      row0_q        <= row0_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.h           = h_q;
  assign bus.v           = v_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.visible     = visible_q;
  assign bus.col0        = col0_q;
  assign bus.row0        = row0_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = fc_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
//
// Five generators share one clock and reset:
//   hdef  - default horizontal timing (800 px/line), 8-line frame
//   small - 8 px/line, 5 lines/frame
//   div3  - small raster, CLK_DIV=3
//   div2  - small raster, CLK_DIV=2, ena dropped mid-prescale
//   pos   - small raster, positive sync polarity
// After reset release, k counts rising edges; expected values are written
// as simple functions of k.
module tb_vga_sync_gen;

  logic clk;
  logic clk_run;
  logic rst_n;
  int   n_checks;
  int   n_bad;
  int   cur_k;
  int   e2;
  logic ena2_before;

  vga_sync_gen_if #(.HW(10), .VW(3), .FRAME_BITS(8)) bus_hdef  ();
  vga_sync_gen_if #(.HW(3),  .VW(3), .FRAME_BITS(8)) bus_small ();
  vga_sync_gen_if #(.HW(3),  .VW(3), .FRAME_BITS(8)) bus_div3  ();
  vga_sync_gen_if #(.HW(3),  .VW(3), .FRAME_BITS(8)) bus_div2  ();
  vga_sync_gen_if #(.HW(3),  .VW(3), .FRAME_BITS(8)) bus_pos   ();

  vga_sync_gen #(
    .V_VIEW(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_hdef (.clk(clk), .rst_n(rst_n), .bus(bus_hdef));

  vga_sync_gen #(
    .H_VIEW(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VIEW(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (.clk(clk), .rst_n(rst_n), .bus(bus_small));

  vga_sync_gen #(
    .H_VIEW(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VIEW(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(3)
  ) u_div3 (.clk(clk), .rst_n(rst_n), .bus(bus_div3));

  vga_sync_gen #(
    .H_VIEW(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VIEW(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(2)
  ) u_div2 (.clk(clk), .rst_n(rst_n), .bus(bus_div2));

  vga_sync_gen #(
    .H_VIEW(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VIEW(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_pos (.clk(clk), .rst_n(rst_n), .bus(bus_pos));

  // Free-running clock that can be parked so reset can be shown to act
  // without any clock edge.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_bad++;
      if (n_bad <= 40)
        $display("[TB] FAIL %s: observed=%0d expected=%0d (k=%0d)",
                 tag, observed, expected, cur_k);
    end
  endtask

  task automatic applyStimulus(input int n_edges);
    repeat (n_edges) @(posedge clk);
    #1;
  endtask

  initial begin
    int hs, vs, hh, vh;
    clk           = 1'b0;
    clk_run       = 1'b1;
    rst_n         = 1'b1;
    n_checks      = 0;
    n_bad         = 0;
    cur_k         = 0;
    e2            = 0;
    bus_hdef.ena  = 1'b1;
    bus_small.ena = 1'b1;
    bus_div3.ena  = 1'b1;
    bus_div2.ena  = 1'b1;
    bus_pos.ena   = 1'b1;

    // Assert reset before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst0_h",           bus_hdef.h, 0);
    checkOutput("rst0_v",           bus_hdef.v, 0);
    checkOutput("rst0_hsync",       bus_hdef.hsync, 1);
    checkOutput("rst0_vsync",       bus_hdef.vsync, 1);
    checkOutput("rst0_visible",     bus_hdef.visible, 1);
    checkOutput("rst0_line_start",  bus_hdef.line_start, 0);
    checkOutput("rst0_frame_start", bus_hdef.frame_start, 0);
    checkOutput("rst0_pos_hsync",   bus_pos.hsync, 0);
    checkOutput("rst0_pos_vsync",   bus_pos.vsync, 0);

    // Release reset just after a rising edge, away from the next one.
    applyStimulus(1);
    rst_n = 1'b1;

    for (int k = 1; k <= 15500; k++) begin
      ena2_before = bus_div2.ena;
      applyStimulus(1);
      cur_k = k;
      if (ena2_before) e2++;

      // Small raster: 8 px (sync at 5..6), 5 lines (sync at line 3).
      hs = k % 8;
      vs = (k / 8) % 5;
      checkOutput("small_h",           bus_small.h, hs);
      checkOutput("small_v",           bus_small.v, vs);
      checkOutput("small_hsync",       bus_small.hsync, (hs == 5 || hs == 6) ? 0 : 1);
      checkOutput("small_vsync",       bus_small.vsync, (vs == 3) ? 0 : 1);
      checkOutput("small_visible",     bus_small.visible, (hs < 4 && vs < 2) ? 1 : 0);
      checkOutput("small_col0",        bus_small.col0, (hs == 0) ? 1 : 0);
      checkOutput("small_row0",        bus_small.row0, (vs == 0) ? 1 : 0);
      checkOutput("small_line_start",  bus_small.line_start, (hs == 0) ? 1 : 0);
      checkOutput("small_frame_start", bus_small.frame_start, (hs == 0 && vs == 0) ? 1 : 0);
      checkOutput("small_frame_count", bus_small.frame_count, (k / 40) % 256);
      if (k == 10239) checkOutput("small_fc_255", bus_small.frame_count, 255);
      if (k == 10240) checkOutput("small_fc_wrap", bus_small.frame_count, 0);

      // Positive polarity: same windows, inverted levels.
      checkOutput("pos_hsync", bus_pos.hsync, (hs == 5 || hs == 6) ? 1 : 0);
      checkOutput("pos_vsync", bus_pos.vsync, (vs == 3) ? 1 : 0);

      // Prescale by 3: each pixel lasts 3 clocks, a line 24 clocks.
      checkOutput("div3_h",          bus_div3.h, (k / 3) % 8);
      checkOutput("div3_line_start", bus_div3.line_start, (k % 24 == 0) ? 1 : 0);

      // Prescale by 2 with ena low over edges 6..15 (h=2, pre=1).
      checkOutput("div2_h", bus_div2.h, (e2 / 2) % 8);
      if (k >= 5 && k <= 15) begin
        checkOutput("div2_freeze_h",     bus_div2.h, 2);
        checkOutput("div2_freeze_pre",   u_div2.pre_q, 1);
        checkOutput("div2_freeze_hsync", bus_div2.hsync, 1);
        checkOutput("div2_freeze_ls",    bus_div2.line_start, 0);
        checkOutput("div2_freeze_fs",    bus_div2.frame_start, 0);
      end
      if (k == 16) checkOutput("div2_resume_h", bus_div2.h, 3);

      // Default horizontal timing: hsync low for 656..751; 8-line frame
      // with vsync low on lines 5..6.
      hh = k % 800;
      vh = (k / 800) % 8;
      checkOutput("hdef_h",           bus_hdef.h, hh);
      checkOutput("hdef_v",           bus_hdef.v, vh);
      checkOutput("hdef_hsync",       bus_hdef.hsync, (hh >= 656 && hh <= 751) ? 0 : 1);
      checkOutput("hdef_vsync",       bus_hdef.vsync, (vh == 5 || vh == 6) ? 0 : 1);
      checkOutput("hdef_visible",     bus_hdef.visible, (hh < 640 && vh < 4) ? 1 : 0);
      checkOutput("hdef_frame_start", bus_hdef.frame_start, (k % 6400 == 0) ? 1 : 0);
      checkOutput("hdef_frame_count", bus_hdef.frame_count, (k / 6400) % 256);
      if (k == 6400) begin
        checkOutput("hdef_wrap_fs", bus_hdef.frame_start, 1);
        checkOutput("hdef_wrap_fc", bus_hdef.frame_count, 1);
      end

      bus_div2.ena = (k >= 5 && k < 15) ? 1'b0 : 1'b1;
    end

    // hdef now sits mid-line at h=300, v=3. Park the clock high, then
    // assert reset: outputs must return to reset values with no edge.
    checkOutput("pre_rst_h", bus_hdef.h, 300);
    checkOutput("pre_rst_v", bus_hdef.v, 3);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst1_h",           bus_hdef.h, 0);
    checkOutput("rst1_v",           bus_hdef.v, 0);
    checkOutput("rst1_frame_count", bus_hdef.frame_count, 0);
    checkOutput("rst1_hsync",       bus_hdef.hsync, 1);
    checkOutput("rst1_vsync",       bus_hdef.vsync, 1);
    checkOutput("rst1_visible",     bus_hdef.visible, 1);
    checkOutput("rst1_col0",        bus_hdef.col0, 1);
    checkOutput("rst1_row0",        bus_hdef.row0, 1);
    checkOutput("rst1_line_start",  bus_hdef.line_start, 0);
    checkOutput("rst1_frame_start", bus_hdef.frame_start, 0);
    checkOutput("rst1_pos_hsync",   bus_pos.hsync, 0);
    checkOutput("rst1_pos_vsync",   bus_pos.vsync, 0);
    checkOutput("rst1_div2_pre",    u_div2.pre_q, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA raster timing generator for the Tiny Tapeout game designs. It produces hsync/vsync, the visible-area flag, the current pixel coordinates, and the col0/row0 debug strobes that a game's `uo_out` pins expose. Compared with the fixed 640x480 counter used so far, it adds:

- fully parametrised porch and sync widths;
- selectable sync polarity;
- a pixel-clock prescaler;
- a run/freeze enable;
- line/frame start pulses and a frame counter.

It sits between `clk`/`rst_n` and the game's pixel-colour logic.

## Interface
Parameters:
- H_VIEW, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_VIEW, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 33: vertical back porch, lines
- H_SYNC_POL, 0: hsync active level (0 = active low)
- V_SYNC_POL, 0: vsync active level (0 = active low)
- CLK_DIV, 1: clk cycles per pixel, ≥1
- FRAME_BITS, 8: width of frame_count

Derived values:
- H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
- HW = clog2(H_TOTAL); VW = clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock domain, reset is asynchronous and active-low
- ena  in  1  run enable; low freezes all timing state
- h  out  HW  current pixel column, 0..H_TOTAL-1
- v  out  VW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- visible  out  1  high when h<H_VIEW and v<V_VIEW
- col0  out  1  high when h==0
- row0  out  1  high when v==0
- line_start  out  1  one-clk pulse when h becomes 0
- frame_start  out  1  one-clk pulse when h and v both become 0
- frame_count  out  FRAME_BITS  completed-frame counter, wraps modulo 2^FRAME_BITS

## Operation
Prescaler:
- Counter `pre` runs 0..CLK_DIV-1.
- Pixel tick `tick` = ena && pre==CLK_DIV-1. With CLK_DIV=1, `tick`=ena.
- `pre` advances only while ena is high.

On each tick:
- h increments.
- At h==H_TOTAL-1, h wraps to 0 and v increments.
- At v==V_TOTAL-1 with h wrapping, v wraps to 0 and frame_count increments, wrapping from 2^FRAME_BITS-1 to 0.

Sync decode:
- hsync is active when h is in [H_VIEW+H_FRONT, H_VIEW+H_FRONT+H_SYNC-1]; otherwise it is at the inactive level.
- vsync is active when v is in [V_VIEW+V_FRONT, V_VIEW+V_FRONT+V_SYNC-1]; otherwise inactive. vsync is line-granular and changes only when h wraps.
- Inactive level = ~POL.

Registering:
- Every output is a flop output.
- hsync, vsync, visible, col0 and row0 are decoded from next-state h/v, so they are consistent with the registered h/v in the same cycle.
- No output is combinational from any input.

Pulses:
- line_start is high for exactly one clk, in the cycle where h first reads 0 after a wrap.
- frame_start is high in that same cycle when v also reads 0.
- Neither pulse is asserted out of reset.

ena low:
- pre, h, v and frame_count hold.
- Level outputs hold.
- line_start and frame_start are 0.
- Resuming continues from the held state with no skipped or repeated pixel.

Reset (async assert, any time including mid-frame): outputs take these values immediately.
- pre=0, h=0, v=0, frame_count=0
- visible=1, col0=1, row0=1
- hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
- line_start=0, frame_start=0

Reset release and parameter checks:
- Reset release is expected synchronous to clk; the first tick occurs CLK_DIV enabled clocks after release.
- Parameter sanity is checked in simulation: every width ≥1 and CLK_DIV ≥1; violation is a fatal error.

## Timing
- Latency from tick to updated h/v/decoded outputs: 1 clk. All outputs change on the same clk edge.
- Each h value persists exactly CLK_DIV enabled clocks.
- Line period = H_TOTAL×CLK_DIV clocks; frame period = H_TOTAL×V_TOTAL×CLK_DIV clocks while ena is held high.
- frame_count increments on the same edge that asserts frame_start.
- Defaults give the 25.175 MHz 640x480@60 mode at CLK_DIV=1: hsync low for h=656..751, vsync low for v=490..491.

## Test plan
- **Reset values:** assert rst_n=0 mid-line (h=300, v=100) with clk stopped. Required: all outputs at their reset values immediately, without a clock edge; hsync=1, vsync=1.
- **Small-raster horizontal decode:** H_VIEW=4, H_FRONT=1, H_SYNC=2, H_BACK=1, CLK_DIV=1, ena=1. Required:
  - h sequence 0..7,0;
  - hsync=0 exactly at h=5,6;
  - visible=1 only at h=0..3;
  - col0 and line_start=1 at h=0 after the wrap.
- **Frame wrap, defaults:** after 800×525 ticks from reset, required:
  - h=0, v=0, frame_start=1 for one clk, frame_count=1;
  - vsync=0 for v=490..491 only;
  - frame_count wraps 255→0 at FRAME_BITS=8.
- **Prescaler:** CLK_DIV=3. Required:
  - each h held 3 clocks;
  - line_start stays a single clk wide;
  - line period = 3×H_TOTAL clocks.
- **ena freeze:** drop ena for 10 clks at h=2 with CLK_DIV=2, mid-prescale. Required:
  - h, v, pre, hsync held;
  - no pulses;
  - h advances after exactly the remaining 1 enabled clk once ena returns.
- **Positive polarity:** H_SYNC_POL=1, V_SYNC_POL=1. Required: reset hsync=vsync=0; sync pulses high with identical windows to the default case.
